// File: rtl/cpu_pkg.sv
// Shared CPU constants for the M-extension unit: decode fields, funct3 codes
// and the muldiv controller state encoding.
package cpu_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 6;

  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIVU  = 3'b101;
  localparam logic [2:0] F3_REMU  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // True for the funct3 codes this unit implements.
  function automatic logic is_supported_f3(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULHU) || (f3 == F3_DIVU) || (f3 == F3_REMU);
  endfunction

  // True for the divide-family funct3 codes.
  function automatic logic is_div_f3(input logic [2:0] f3);
    return (f3 == F3_DIVU) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> muldiv unit bus.
//   master: pipeline side, drives valid_in/I_in/rs1_data/rs2_data,
//           receives stall/busy/ready_out/result.
//   slave : muldiv unit side.
interface muldiv_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_in;
  logic [31:0]     I_in;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            stall;
  logic            busy;
  logic            ready_out;
  logic [XLEN-1:0] result;

  modport master (
    output valid_in, I_in, rs1_data, rs2_data,
    input  stall, busy, ready_out, result
  );

  modport slave (
    input  valid_in, I_in, rs1_data, rs2_data,
    output stall, busy, ready_out, result
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath, one bit per i_step.
//   i_load   : latch op and operands, clear accumulator/remainder/quotient
//   i_div0   : with i_load, preset divide-by-zero results
//   i_step   : perform one iteration of the latched op
//   i_op     : funct3 of the instruction being loaded
//   i_rs1/2  : operand A / operand B
//   o_result_c : result selected from the latched op (valid once iteration ends)
module muldiv_datapath
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_div0,
  input  logic            i_step,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic [XLEN-1:0] o_result_c
);

  logic [2:0]        r_op;
  logic [2*XLEN-1:0] r_acc;   // multiply product accumulator
  logic [XLEN-1:0]   r_opa;   // multiplicand / dividend (shifts left when dividing)
  logic [XLEN-1:0]   r_opb;   // multiplier (shifts right) / divisor
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_ge;

  // Multiply step: add multiplicand into upper half when multiplier LSB set.
  assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_opb[0] ? r_opa : '0)};

  // Divide step: remainder < divisor holds between steps, so the difference
  // always fits in XLEN bits when w_ge is true.
  assign w_rem_sh = {r_rem, r_opa[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_opb});
  assign w_diff   = w_rem_sh - {1'b0, r_opb};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_acc <= '0;
      r_opa <= '0;
      r_opb <= '0;
      r_rem <= '0;
      r_quo <= '0;
    end else if (i_load) begin
      r_op  <= i_op;
      r_acc <= '0;
      r_opa <= i_rs1;
      r_opb <= i_rs2;
      r_rem <= i_div0 ? i_rs1 : '0;
      r_quo <= i_div0 ? '1    : '0;
    end else if (i_step) begin
      if (is_div_f3(r_op)) begin
        r_opa <= {r_opa[XLEN-2:0], 1'b0};
        r_rem <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], w_ge};
      end else begin
        r_acc <= {w_sum, r_acc[XLEN-1:1]};
        r_opb <= {1'b0, r_opb[XLEN-1:1]};
      end
    end
  end

  // Unsupported funct3 codes fall through to zero.
  always_comb begin
    o_result_c = '0;
    case (r_op)
      F3_MUL:   o_result_c = r_acc[XLEN-1:0];
      F3_MULHU: o_result_c = r_acc[2*XLEN-1:XLEN];
      F3_DIVU:  o_result_c = r_quo;
      F3_REMU:  o_result_c = r_rem;
      default:  o_result_c = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MUL/MULHU/DIVU/REMU unit beside the EX-stage ALU.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.valid_in/I_in/rs1_data/rs2_data : instruction and operands in EX
//   bus.stall     : freeze PC and IF/ID/EX (combinational on the accept cycle)
//   bus.busy      : controller not idle
//   bus.ready_out : result valid this cycle (DONE)
//   bus.result    : result in DONE, zero otherwise
module muldiv_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_ctrl_if.slave bus
);

  muldiv_state_t    r_state;
  muldiv_state_t    w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic             w_is_m;
  logic [2:0]       w_f3;
  logic             w_start;
  logic             w_direct_done;
  logic             w_div0;
  logic             w_load;
  logic             w_step;
  logic [XLEN-1:0]  w_result;
  logic             w_unused_fields;

  assign w_f3   = bus.I_in[14:12];
  assign w_is_m = (bus.I_in[6:0] == OPCODE_RTYPE) && (bus.I_in[31:25] == FUNCT7_MULDIV);
  // Register specifiers are decoded elsewhere; only opcode/funct fields matter here.
  assign w_unused_fields = ^{bus.I_in[24:15], bus.I_in[11:7]};

  // Gated by rst_n so nothing is accepted (or stalled) while held in reset.
  assign w_start       = rst_n && bus.valid_in && (r_state == IDLE) && w_is_m;
  assign w_div0        = is_div_f3(w_f3) && (bus.rs2_data == '0);
  assign w_direct_done = !is_supported_f3(w_f3) || w_div0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath controls.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_load      = 1'b1;
          w_state_nxt = w_direct_done ? DONE : CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == '0) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Iteration counter: XLEN-1 down to 0, one step per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= CNT_W'(XLEN - 1);
    end else if (w_step && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_div0     (w_div0),
    .i_step     (w_step),
    .i_op       (w_f3),
    .i_rs1      (bus.rs1_data),
    .i_rs2      (bus.rs2_data),
    .o_result_c (w_result)
  );

  assign bus.stall     = w_start || (r_state == CALC);
  assign bus.busy      = (r_state != IDLE);
  assign bus.ready_out = (r_state == DONE);
  assign bus.result    = (r_state == DONE) ? w_result : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed vector table, reset and non-M
// sequences, and random operations checked against an arithmetic model.
module tb_muldiv_ctrl;
  import cpu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  muldiv_ctrl_if #(.XLEN(XLEN)) bus ();

  muldiv_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_instr(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Reference model: plain wide arithmetic from the ISA definition.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (f3)
      3'b000:  return p[31:0];
      3'b011:  return p[63:32];
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b111:  return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one instruction in the IDLE cycle, hold it while stalled, check DONE.
  task automatic run_op(input string nm, input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k;
    int n_st;
    int n_res;
    bit got;
    @(negedge clk);
    chk({nm, "_idle_busy"}, 64'(bus.busy), 64'd0);
    bus.valid_in = 1'b1;
    bus.I_in     = instr;
    bus.rs1_data = a;
    bus.rs2_data = b;
    #1;
    chk({nm, "_stall_T"}, 64'(bus.stall), 64'd1);
    k = 0; n_st = 0; n_res = 0; got = 1'b0;
    while (k < 40 && !got) begin
      @(negedge clk);
      k++;
      if (bus.ready_out) got = 1'b1;
      else begin
        if (bus.stall) n_st++;
        if (bus.result != 0) n_res++;
      end
    end
    chk({nm, "_latency"}, 64'(k), 64'(lat));
    chk({nm, "_stall_cycles"}, 64'(n_st), 64'(lat - 1));
    chk({nm, "_result_zero_before_done"}, 64'(n_res), 64'd0);
    chk({nm, "_result"}, 64'(bus.result), 64'(exp));
    chk({nm, "_stall_done"}, 64'(bus.stall), 64'd0);
    chk({nm, "_busy_done"}, 64'(bus.busy), 64'd1);
    bus.valid_in = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    int n_bad;
    n_cmp = 0;
    n_err = 0;

    vecs.push_back('{"mul_7x6",      3'b000, 32'd7,          32'd6,          32'd42,         33});
    vecs.push_back('{"mulhu_ff",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33});
    vecs.push_back('{"mul_ff",       3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33});
    vecs.push_back('{"divu_100_7",   3'b101, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{"remu_100_7",   3'b111, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{"divu_ff_1",    3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
    vecs.push_back('{"divu_123_0",   3'b101, 32'd123,        32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{"remu_123_0",   3'b111, 32'd123,        32'd0,          32'd123,        1});
    vecs.push_back('{"mulh_unsup",   3'b001, 32'd9,          32'd9,          32'd0,          1});
    vecs.push_back('{"divu_small",   3'b101, 32'd3,          32'd10,         32'd0,          33});
    vecs.push_back('{"remu_max",     3'b111, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          33});

    bus.valid_in = 1'b0;
    bus.I_in     = 32'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_stall", 64'(bus.stall), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_ready", 64'(bus.ready_out), 64'd0);
    chk("reset_result", 64'(bus.result), 64'd0);
    rst_n = 1'b1;

    // Directed table, issued back to back.
    foreach (vecs[i])
      run_op(vecs[i].name, m_instr(vecs[i].f3), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Non-M ADD and an M pattern without valid_in must never engage the unit.
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.I_in     = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    n_bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.stall || bus.busy || bus.ready_out) n_bad++;
      @(negedge clk);
    end
    chk("add_untouched", 64'(n_bad), 64'd0);
    bus.valid_in = 1'b0;
    bus.I_in     = m_instr(3'b000);
    n_bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.stall || bus.busy || bus.ready_out) n_bad++;
      @(negedge clk);
    end
    chk("invalid_m_untouched", 64'(n_bad), 64'd0);

    // Reset in the middle of a multiply discards it.
    bus.valid_in = 1'b1;
    bus.I_in     = m_instr(3'b000);
    bus.rs1_data = 32'd7;
    bus.rs2_data = 32'd6;
    repeat (10) @(negedge clk);
    chk("midcalc_busy", 64'(bus.busy), 64'd1);
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    chk("midcalc_rst_stall", 64'(bus.stall), 64'd0);
    chk("midcalc_rst_busy", 64'(bus.busy), 64'd0);
    chk("midcalc_rst_ready", 64'(bus.ready_out), 64'd0);
    chk("midcalc_rst_result", 64'(bus.result), 64'd0);
    rst_n = 1'b1;
    run_op("mul_3x5_after_rst", m_instr(3'b000), 32'd3, 32'd5, 32'd15, 33);

    // Random operations against the model.
    for (int r = 0; r < 24; r++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      case ($urandom_range(3, 0))
        0: f3 = 3'b000;
        1: f3 = 3'b011;
        2: f3 = 3'b101;
        default: f3 = 3'b111;
      endcase
      a = $urandom();
      b = ($urandom_range(5, 0) == 0) ? 32'd0 : $urandom() >> $urandom_range(31, 0);
      lat = ((f3 == 3'b101 || f3 == 3'b111) && b == 0) ? 1 : 33;
      run_op($sformatf("rand%0d_f3_%0d", r, f3), m_instr(f3), a, b, model(f3, a, b), lat);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative unsigned multiply/divide unit for the RV32 CPU's M-extension subset: MUL, MULHU, DIVU, REMU.
- Has its own controller FSM and counter. It sits beside the ALU in EX.
- When an M instruction arrives, it latches the operands, stalls the pipeline while it iterates one bit per cycle, then presents the result for one cycle.
- Non-M instructions pass untouched; the unit stays idle and never stalls for them.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- valid_in  input  1  EX stage holds a valid instruction.
- I_in  input  32  instruction word in EX.
- rs1_data  input  XLEN  operand A (multiplicand / dividend).
- rs2_data  input  XLEN  operand B (multiplier / divisor).
- stall  output  1  freeze PC and IF/ID/EX registers.
- busy  output  1  FSM not in IDLE.
- ready_out  output  1  result valid this cycle.
- result  output  XLEN  MUL/MULHU/DIVU/REMU result.

Behaviour:
- Decode: start = valid_in & state==IDLE & I_in[6:0]==7'b0110011 & I_in[31:25]==7'b0000001.
  - funct3 I_in[14:12]: 000 MUL (low word), 011 MULHU (high word), 101 DIVU, 111 REMU.
  - Any other funct3 with the M pattern: treated as unsupported. Goes IDLE->DONE directly, result 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE->CALC on start with a supported op and nonzero divisor (or any multiply).
  - IDLE->DONE on start with DIVU/REMU and rs2_data==0, or with an unsupported funct3.
  - CALC->DONE when cnt==0 after the iteration step; otherwise stay in CALC, cnt decrements.
  - DONE->IDLE unconditionally. valid_in/I_in are ignored in DONE because the pipeline still shows the same instruction that cycle.
- On start: latch op, rs1_data, rs2_data; set cnt=XLEN-1; clear the 2*XLEN accumulator.
- Multiply, shift-add, one bit per cycle:
  - if multiplier LSB is set, upper half += multiplicand (XLEN+1-bit add, carry kept);
  - then shift {carry, acc} right by 1 and shift the multiplier right by 1.
  - After XLEN steps: MUL = acc[XLEN-1:0], MULHU = acc[2*XLEN-1:XLEN].
- Divide, restoring, one bit per cycle:
  - rem = {rem, dividend MSB}; dividend shifts left;
  - if rem >= divisor: rem -= divisor, quotient bit = 1; else quotient bit = 0.
  - DIVU = quotient, REMU = rem.
- Divide by zero: DIVU result = all ones (0xFFFFFFFF); REMU result = dividend. Latency 1 cycle.
- Latency: start in cycle T, CALC in T+1..T+XLEN, DONE (ready_out=1) in T+XLEN+1. Divide-by-zero and unsupported ops: DONE in T+1.
- stall = start | (state==CALC). stall is combinational so the accept cycle freezes the pipeline. stall=0 in DONE so the pipeline advances with the result.
- ready_out=1 only in DONE. result holds its value in DONE only and is 0 in all other states.
- busy = (state != IDLE).
- Reset (rst_n=0 at a clock edge), including mid-CALC: state=IDLE, cnt=0, all registers 0, stall=0, busy=0, ready_out=0, result=0. Any in-flight operation is discarded.
- Back-to-back M instructions: the second can start in the IDLE cycle after DONE. Minimum spacing is XLEN+2 cycles.

Decomposition:
- Shared package (cpu_pkg):
  - OPCODE_RTYPE=7'b0110011, FUNCT7_MULDIV=7'b0000001;
  - F3_MUL=3'b000, F3_MULHU=3'b011, F3_DIVU=3'b101, F3_REMU=3'b111;
  - the state encoding IDLE=2'd0, CALC=2'd1, DONE=2'd2.
- One sub-module is natural: muldiv_datapath. It holds the accumulator, shift registers and adder/subtractor, driven by load/step/op signals from the FSM in muldiv_ctrl.

Test Plan:
- MUL 7*6: start at T -> stall=1 during T..T+32; ready_out=1 with result=42 at T+33; stall=0 at T+33.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE at T+33. Same operands with MUL -> result=0x00000001.
- DIVU 100/7 -> result=14; REMU 100/7 -> result=2. Both ready at T+33. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- DIVU 123/0 -> ready_out=1 at T+1, result=0xFFFFFFFF. REMU 123/0 -> result=123. stall high only in cycle T.
- Non-M ADD (funct7=0) with valid_in=1 -> stall=0, busy=0 throughout, ready_out never asserted.
- MUL 7*6 with rst_n=0 at T+10 -> from T+11: state IDLE, stall=0, busy=0, result=0. A new MUL 3*5 then returns 15 with full latency.
